// File: rtl/pam_4_slicer_deser.sv
// PAM-4 slicer and symbol deserializer: slices signed samples into 2-bit symbols,
// packs them MSB-first into words, and counts accepted and low-margin samples.
module pam_4_slicer_deser #(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 64,
    parameter int SYMBOLS_PER_WORD  = 4,
    parameter int MARGIN            = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [SIGNAL_RESOLUTION-1:0]    voltage_level_in,
    input  logic                            voltage_level_in_valid,
    output logic                            voltage_level_in_ready,
    input  logic                            align_clear,
    output logic [2*SYMBOLS_PER_WORD-1:0]   word_out,
    output logic                            word_out_valid,
    input  logic                            word_out_ready,
    output logic [31:0]                     symbol_count,
    output logic [15:0]                     low_margin_count
);
    localparam int W  = SIGNAL_RESOLUTION;
    localparam int EW = SIGNAL_RESOLUTION + 2;
    localparam int WW = 2 * SYMBOLS_PER_WORD;
    localparam int IW = (SYMBOLS_PER_WORD > 1) ? $clog2(SYMBOLS_PER_WORD) : 1;
    localparam logic [IW-1:0]        LAST  = IW'(SYMBOLS_PER_WORD - 1);
    localparam logic signed [EW-1:0] S_POS = EW'(SYMBOL_SEPERATION);
    localparam logic signed [EW-1:0] S_NEG = -S_POS;
    localparam logic signed [EW-1:0] MARG  = EW'(MARGIN);

    logic [IW-1:0]          idx, eff_idx;
    logic [WW-1:0]          part_word, base_word, ins_word;
    logic signed [EW-1:0]   v_ext, d_lo, d_mid, d_hi, a_lo, a_mid, a_hi;
    logic [1:0]             sym;
    logic                   low_margin, accept, last;

    function automatic logic signed [EW-1:0] abs_e(input logic signed [EW-1:0] d);
        return d[EW-1] ? -d : d;
    endfunction

    // Sign-extended by two bits so v +/- S never wraps, whatever the sample.
    assign v_ext = {{2{voltage_level_in[W-1]}}, voltage_level_in};
    assign d_lo  = v_ext - S_NEG;
    assign d_mid = v_ext;
    assign d_hi  = v_ext - S_POS;
    assign a_lo  = abs_e(d_lo);
    assign a_mid = abs_e(d_mid);
    assign a_hi  = abs_e(d_hi);
    assign low_margin = (a_lo < MARG) || (a_mid < MARG) || (a_hi < MARG);

    always_comb begin
        sym = 2'b11;
        if (v_ext < S_NEG)       sym = 2'b00;
        else if (v_ext[EW-1])    sym = 2'b01;
        else if (v_ext < S_POS)  sym = 2'b10;
    end

    // Only the slot that would complete a word is blocked by a stalled output.
    assign voltage_level_in_ready = !((idx == LAST) && word_out_valid && !word_out_ready);
    assign accept = voltage_level_in_valid && voltage_level_in_ready;

    // align_clear restarts packing this cycle, so a coincident sample lands at slot 0.
    always_comb begin
        eff_idx   = align_clear ? '0 : idx;
        base_word = align_clear ? '0 : part_word;
        ins_word  = base_word;
        for (int i = 0; i < SYMBOLS_PER_WORD; i++)
            if (eff_idx == IW'(i)) ins_word[2*(SYMBOLS_PER_WORD-i)-1 -: 2] = sym;
        last = (eff_idx == LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx              <= '0;
            part_word        <= '0;
            word_out         <= '0;
            word_out_valid   <= 1'b0;
            symbol_count     <= '0;
            low_margin_count <= '0;
        end else begin
            if (accept) begin
                part_word <= last ? '0 : ins_word;
                idx       <= last ? '0 : eff_idx + IW'(1);
            end else if (align_clear) begin
                part_word <= '0;
                idx       <= '0;
            end
            if (accept && last) begin
                word_out       <= ins_word;
                word_out_valid <= 1'b1;
            end else if (word_out_ready) begin
                word_out_valid <= 1'b0;
            end
            if (accept && symbol_count != '1)
                symbol_count <= symbol_count + 32'd1;
            if (accept && low_margin && low_margin_count != '1)
                low_margin_count <= low_margin_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_pam_4_slicer_deser.sv
// Directed bench for pam_4_slicer_deser at default parameters.
module tb_pam_4_slicer_deser;
    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  vin;
    logic        vin_valid;
    logic        vin_ready;
    logic        align_clear;
    logic [7:0]  word_out;
    logic        word_out_valid;
    logic        word_out_ready;
    logic [31:0] symbol_count;
    logic [15:0] low_margin_count;

    int total = 0;
    int bad   = 0;

    pam_4_slicer_deser dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .voltage_level_in       (vin),
        .voltage_level_in_valid (vin_valid),
        .voltage_level_in_ready (vin_ready),
        .align_clear            (align_clear),
        .word_out               (word_out),
        .word_out_valid         (word_out_valid),
        .word_out_ready         (word_out_ready),
        .symbol_count           (symbol_count),
        .low_margin_count       (low_margin_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int v);
        vin       = 8'(v);
        vin_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        vin_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        #2 rstn = 1'b0;
        #1;
        chk("rst_word",  32'(word_out), 32'h0);
        chk("rst_valid", 32'(word_out_valid), 32'h0);
        chk("rst_sc",    symbol_count, 32'd0);
        chk("rst_lm",    32'(low_margin_count), 32'd0);
        chk("rst_ready", 32'(vin_ready), 32'd1);
        @(negedge clk) rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; vin = '0; vin_valid = 1'b0; align_clear = 1'b0; word_out_ready = 1'b1;
        #3;
        chk("init_word",  32'(word_out), 32'h0);
        chk("init_valid", 32'(word_out_valid), 32'h0);
        chk("init_sc",    symbol_count, 32'd0);
        chk("init_lm",    32'(low_margin_count), 32'd0);
        chk("init_ready", 32'(vin_ready), 32'd1);
        @(negedge clk) rstn = 1'b1;

        // ideal levels
        send(-96); send(-32); send(32);
        chk("ideal_pre_valid", 32'(word_out_valid), 32'd0);
        send(96);
        chk("ideal_word",  32'(word_out), 32'h1B);
        chk("ideal_valid", 32'(word_out_valid), 32'd1);
        chk("ideal_sc",    symbol_count, 32'd4);
        chk("ideal_lm",    32'(low_margin_count), 32'd0);
        idle();
        chk("ideal_drain", 32'(word_out_valid), 32'd0);

        // threshold samples, all low-margin
        send(-64); send(0); send(64); send(-65);
        chk("thr_word", 32'(word_out), 32'h6C);
        chk("thr_lm",   32'(low_margin_count), 32'd4);
        chk("thr_sc",   symbol_count, 32'd8);
        idle();

        // backpressure
        word_out_ready = 1'b0;
        repeat (4) send(-96);
        chk("bp_word0",  32'(word_out), 32'h00);
        chk("bp_valid0", 32'(word_out_valid), 32'd1);
        repeat (3) send(96);
        chk("bp_ready_lo", 32'(vin_ready), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("bp_hold_ready", 32'(vin_ready), 32'd0);
        chk("bp_hold_word",  32'(word_out), 32'h00);
        chk("bp_hold_valid", 32'(word_out_valid), 32'd1);
        chk("bp_hold_sc",    symbol_count, 32'd15);
        word_out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(vin_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_word1",  32'(word_out), 32'hFF);
        chk("bp_valid1", 32'(word_out_valid), 32'd1);
        chk("bp_sc",     symbol_count, 32'd16);
        idle();
        chk("bp_drain", 32'(word_out_valid), 32'd0);
        chk("bp_lm",    32'(low_margin_count), 32'd4);

        // reset mid-word
        send(96); send(96);
        vin_valid = 1'b0;
        pulse_reset();
        send(96); send(96); send(-96); send(-96);
        chk("rst_after_word",  32'(word_out), 32'hF0);
        chk("rst_after_valid", 32'(word_out_valid), 32'd1);
        chk("rst_after_sc",    symbol_count, 32'd4);
        idle();

        // align_clear with coincident accept
        pulse_reset();
        send(96); send(96); send(96);
        align_clear = 1'b1;
        send(-32);
        align_clear = 1'b0;
        chk("al_no_word", 32'(word_out_valid), 32'd0);
        chk("al_sc4",     symbol_count, 32'd4);
        send(-32); send(-32);
        chk("al_still_partial", 32'(word_out_valid), 32'd0);
        send(-32);
        chk("al_word",  32'(word_out), 32'h55);
        chk("al_valid", 32'(word_out_valid), 32'd1);
        chk("al_sc",    symbol_count, 32'd7);
        chk("al_lm",    32'(low_margin_count), 32'd0);
        idle();

        // margin boundaries: 7 and -57 are low, 8 and 56 are not
        send(7); send(8); send(-57); send(56);
        chk("mg_word", 32'(word_out), 32'hA6);
        chk("mg_lm",   32'(low_margin_count), 32'd2);
        // extreme codes slice normally
        send(-128); send(127); send(127); send(-128);
        chk("ext_word", 32'(word_out), 32'h3C);
        chk("ext_sc",   symbol_count, 32'd15);
        chk("ext_lm",   32'(low_margin_count), 32'd2);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pam_4_slicer_deser.md
PAM_4_SLICER_DESER -- requirements
Module: pam_4_slicer_deser

Interface
REQ-001 SHALL have parameter SIGNAL_RESOLUTION, default 8: width of the signed two's-complement voltage sample.
REQ-002 SHALL have parameter SYMBOL_SEPERATION, default 64: spacing between adjacent PAM-4 levels. The encoder levels are -1.5S, -0.5S, +0.5S and +1.5S.
REQ-003 SHALL have parameter SYMBOLS_PER_WORD, default 4: number of symbols packed into each output word.
REQ-004 SHALL have parameter MARGIN, default 8: distance from a slicing threshold inside which a sample counts as low-margin.
REQ-005 clk  in  1  single clock; all logic acts on its rising edge.
REQ-006 rstn  in  1  reset, asynchronous assert, active-low.
REQ-007 voltage_level_in  in  SIGNAL_RESOLUTION  signed received sample, which can be noisy.
REQ-008 voltage_level_in_valid  in  1  sample qualifier.
REQ-009 voltage_level_in_ready  out  1  block can accept a sample this cycle.
REQ-010 align_clear  in  1  synchronous pulse that discards any partial word.
REQ-011 word_out  out  2*SYMBOLS_PER_WORD  packed symbols, first-received symbol in the MSBs.
REQ-012 word_out_valid  out  1  word_out holds a complete word.
REQ-013 word_out_ready  in  1  downstream accepts word_out.
REQ-014 symbol_count  out  32  count of accepted symbols, saturating.
REQ-015 low_margin_count  out  16  count of accepted low-margin samples, saturating.

Function
REQ-016 A sample SHALL be accepted in any cycle where voltage_level_in_valid and voltage_level_in_ready are both 1.
REQ-017 Slicing SHALL be signed and at SIGNAL_RESOLUTION width, with S = SYMBOL_SEPERATION:
  - v < -S gives 2'b00
  - -S <= v < 0 gives 2'b01
  - 0 <= v < S gives 2'b10
  - v >= S gives 2'b11
REQ-018 An accepted sample SHALL be low-margin when |v-(-S)|, |v| or |v-S| is strictly less than MARGIN. Intermediate arithmetic SHALL use SIGNAL_RESOLUTION+2 bits so it cannot overflow.
REQ-019 A packing index SHALL run from 0 to SYMBOLS_PER_WORD-1. The symbol at index i SHALL go to bits [2*(SYMBOLS_PER_WORD-i)-1 -: 2]. The index SHALL increment on each accept and wrap to 0 after SYMBOLS_PER_WORD-1.
REQ-020 When the symbol at index SYMBOLS_PER_WORD-1 is accepted in cycle N, the completed word SHALL load into word_out and word_out_valid SHALL be 1 from cycle N+1.
REQ-021 word_out and word_out_valid SHALL stay stable while word_out_valid=1 and word_out_ready=0.
REQ-022 word_out_valid SHALL clear after a cycle with word_out_ready=1, unless a new word loads in that same cycle; in that case it stays 1 with the new data.
REQ-023 voltage_level_in_ready SHALL be 0 only when index=SYMBOLS_PER_WORD-1, word_out_valid=1 and word_out_ready=0. The ready path is combinational from word_out_ready.
REQ-024 Partial words SHALL never overwrite word_out.
REQ-025 When align_clear=1, the index SHALL go to 0 and the partial word SHALL be discarded.
REQ-026 If a sample is accepted in the same cycle as align_clear, it SHALL be stored at index 0 and the index SHALL become 1.
REQ-027 align_clear SHALL NOT affect word_out, word_out_valid or either counter.
REQ-028 symbol_count SHALL increment by 1 per accept and hold at 2^32-1.
REQ-029 low_margin_count SHALL increment by 1 per low-margin accept and hold at 2^16-1.
REQ-030 The block SHALL not flag any error for out-of-range samples; every value slices per REQ-017.

Reset
REQ-031 While rstn=0 the block SHALL drive:
  - word_out=0, word_out_valid=0
  - index and partial word = 0
  - symbol_count=0, low_margin_count=0
  - voltage_level_in_ready=1
REQ-032 Reset SHALL take effect immediately on rstn falling, including mid-word and mid-backpressure; any partial or pending word SHALL be lost.
REQ-033 On the first rising edge after rstn rises, the block SHALL accept samples normally.

Verification (defaults SIGNAL_RESOLUTION=8, SYMBOL_SEPERATION=64, SYMBOLS_PER_WORD=4, MARGIN=8)
REQ-034 Ideal levels -96, -32, 32, 96 on consecutive cycles with word_out_ready=1 -> word_out=8'h1B with valid one cycle after the 4th accept; symbol_count=4; low_margin_count=0.
REQ-035 Threshold samples -64, 0, 64, -65 -> symbols 01, 10, 11, 00 and word_out=8'h6C; low_margin_count=4.
REQ-036 word_out_ready=0, 8 samples (-96 x4, then 96 x4) offered every cycle:
  - word 8'h00 is held.
  - the 8th sample sees voltage_level_in_ready=0 until word_out_ready goes to 1.
  - word 8'hFF then follows one cycle after its accept.
REQ-037 Two samples accepted, then rstn pulsed low -> all outputs zero while low. After release, samples 96, 96, -96, -96 -> word 8'hF0 and symbol_count=4.
REQ-038 Three samples of 96, then align_clear together with an accepted -32, then -32, -32, -32 -> single word 8'h55 and symbol_count=7.
